// File: rtl/pixel_array_readout_seq_if.sv
// Pixel word stream leaving the readout sequencer: valid/ready handshake carrying the
// pixel code tagged with its row and column.
interface pixel_array_readout_seq_if #(
    parameter int RESOLUTION = 8,
    parameter int ROW_W      = 2,
    parameter int COL_W      = 2
);
    logic                  valid;
    logic                  ready;
    logic [RESOLUTION-1:0] data;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic                  last;

    modport master (output valid, data, row, col, last, input ready);
    modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/pixel_array_readout_seq.sv
// Frame sequencer: global erase/expose, then per-row ADC capture and back-pressured readout.
// Define PIXEL_READOUT_TIMEOUT_EN to bound each CONVERT phase and flag stuck columns.
module pixel_array_readout_seq #(
    parameter int ROWS           = 3,
    parameter int COLUMNS        = 3,
    parameter int RESOLUTION     = 8,
    parameter int ERASE_CYCLES   = 4,
    parameter int EXPOSE_CYCLES  = 16,
    parameter int ROW_W          = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W          = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          erase,
    output logic                          expose,
    output logic                          adc_enable,
    output logic [ROW_W-1:0]              row_select,
    input  logic [COLUMNS-1:0]            col_done,
    input  logic [COLUMNS*RESOLUTION-1:0] col_data,
    pixel_array_readout_seq_if.master     pix,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_err
);
    localparam int PhaseMax = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int CntMax   = (PhaseMax > TIMEOUT_CYCLES) ? PhaseMax : TIMEOUT_CYCLES;
    localparam int CNT_W    = $clog2(CntMax + 1);

    localparam logic [CNT_W-1:0] EraseLast  = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ExposeLast = CNT_W'(EXPOSE_CYCLES - 1);
    localparam logic [ROW_W-1:0] RowLast    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] ColLast    = COL_W'(COLUMNS - 1);
`ifdef PIXEL_READOUT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {StIdle, StErase, StExpose, StConvert, StDrain, StDone} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic                  erase_q, expose_q, adc_q, valid_q, frame_done_q;
    logic [RESOLUTION-1:0] buf_q [COLUMNS];
`ifdef PIXEL_READOUT_TIMEOUT_EN
    logic                  timeout_q;
`endif

    logic                          all_done, timed_out, capture;
    logic [COLUMNS*RESOLUTION-1:0] masked_data;

    always_comb begin
        all_done  = &col_done;
        timed_out = 1'b0;
`ifdef PIXEL_READOUT_TIMEOUT_EN
        timed_out = !all_done && (cnt_q == TimeoutLast);
`endif
        capture   = (state_q == StConvert) && (all_done || timed_out);
        // Columns that never finished read as code 0.
        for (int k = 0; k < COLUMNS; k++) begin
            masked_data[k*RESOLUTION +: RESOLUTION] =
                col_data[k*RESOLUTION +: RESOLUTION] & {RESOLUTION{col_done[k]}};
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < COLUMNS; k++) begin
                buf_q[k] <= masked_data[k*RESOLUTION +: RESOLUTION];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            adc_q        <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PIXEL_READOUT_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StErase;
                        erase_q <= 1'b1;
                        cnt_q   <= '0;
`ifdef PIXEL_READOUT_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                StErase: begin
                    if (cnt_q == EraseLast) begin
                        state_q  <= StExpose;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StExpose: begin
                    if (cnt_q == ExposeLast) begin
                        state_q  <= StConvert;
                        expose_q <= 1'b0;
                        adc_q    <= 1'b1;
                        row_q    <= '0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StConvert: begin
                    if (all_done || timed_out) begin
                        state_q <= StDrain;
                        adc_q   <= 1'b0;
                        col_q   <= '0;
                        valid_q <= 1'b1;
`ifdef PIXEL_READOUT_TIMEOUT_EN
                        if (timed_out) timeout_q <= 1'b1;
`endif
                    end
`ifdef PIXEL_READOUT_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                StDrain: begin
                    if (pix.ready) begin
                        if (col_q != ColLast) begin
                            col_q <= col_q + COL_W'(1);
                        end else if (row_q != RowLast) begin
                            state_q <= StConvert;
                            row_q   <= row_q + ROW_W'(1);
                            col_q   <= '0;
                            valid_q <= 1'b0;
                            adc_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q      <= StDone;
                            row_q        <= '0;
                            col_q        <= '0;
                            valid_q      <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign adc_enable = adc_q;
    assign row_select = row_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;
`ifdef PIXEL_READOUT_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign pix.valid = valid_q;
    assign pix.data  = valid_q ? buf_q[col_q] : '0;
    assign pix.row   = row_q;
    assign pix.col   = col_q;
    assign pix.last  = valid_q && (row_q == RowLast) && (col_q == ColLast);
endmodule

// File: tb/tb_pixel_array_readout_seq.sv
// Randomized bench for pixel_array_readout_seq: frame timing, capture latency, back-pressure,
// reset mid-frame, and (with PIXEL_READOUT_TIMEOUT_EN) the CONVERT timeout.
module tb_pixel_array_readout_seq;
    localparam int ROWS           = 3;
    localparam int COLUMNS        = 3;
    localparam int RESOLUTION     = 8;
    localparam int ERASE_CYCLES   = 2;
    localparam int EXPOSE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int ROW_W          = 2;
    localparam int COL_W          = 2;
    localparam logic [COLUMNS-1:0] ALL_DONE = '1;
`ifdef PIXEL_READOUT_TIMEOUT_EN
    localparam int PART_HOLD = 6;
`else
    localparam int PART_HOLD = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
        bit         last;
    } word_t;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic                          start = 1'b0;
    logic                          erase, expose, adc_enable, busy, frame_done, timeout_err;
    logic [ROW_W-1:0]              row_select;
    logic [COLUMNS-1:0]            col_done = '0;
    logic [COLUMNS*RESOLUTION-1:0] col_data = '0;
    int                            total = 0;
    int                            bad = 0;
    word_t                         exp_q[$];

    pixel_array_readout_seq_if #(.RESOLUTION(RESOLUTION), .ROW_W(ROW_W), .COL_W(COL_W)) pix ();

    pixel_array_readout_seq #(
        .ROWS(ROWS), .COLUMNS(COLUMNS), .RESOLUTION(RESOLUTION),
        .ERASE_CYCLES(ERASE_CYCLES), .EXPOSE_CYCLES(EXPOSE_CYCLES),
        .ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase), .expose(expose),
        .adc_enable(adc_enable), .row_select(row_select), .col_done(col_done),
        .col_data(col_data), .pix(pix), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({erase, expose, adc_enable, busy, frame_done, timeout_err}), 0);
        check({tag, "_rowsel"}, 32'(row_select), 0);
        check({tag, "_pix"}, 32'({pix.valid, pix.data, pix.row, pix.col, pix.last}), 0);
    endtask

    // mode 0: random, 1: directed plan values, 2: timeout on row 0. abort_row: reset mid-drain.
    task automatic run_frame(input int mode, input int abort_row, input bit chain);
        int         n;
        bit         busy_ok;
        bit         te;
        logic [7:0] w [COLUMNS];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("timeout_clear", 32'(timeout_err), 0);
        n = 0;
        busy_ok = 1'b1;
        while (erase && n < 50) begin
            busy_ok &= busy;
            n++;
            @(negedge clk);
        end
        check("erase_len", n, ERASE_CYCLES);
        n = 0;
        while (expose && n < 50) begin
            busy_ok &= busy;
            n++;
            @(negedge clk);
        end
        check("expose_len", n, EXPOSE_CYCLES);
        check("busy_prolog", 32'(busy_ok), 1);

        for (int r = 0; r < ROWS; r++) begin
            int               xfers;
            int               k;
            int               hold;
            bit               early;
            logic [COLUMNS-1:0] part;
            word_t            e;
            check($sformatf("adc_en_r%0d", r), 32'(adc_enable), 1);
            check($sformatf("row_sel_r%0d", r), 32'(row_select), r);
            check($sformatf("valid_conv_r%0d", r), 32'(pix.valid), 0);
            for (int c = 0; c < COLUMNS; c++) begin
                w[c] = (mode == 1 && r == 0) ? 8'(16 * (c + 1)) : 8'($urandom);
                col_data[c*RESOLUTION +: RESOLUTION] = w[c];
            end
`ifdef PIXEL_READOUT_TIMEOUT_EN
            if (mode == 2 && r == 0) begin
                col_done = 3'b011;
                n = 0;
                while (!pix.valid && n < 40) begin
                    pix.ready = 1'($urandom);
                    n++;
                    @(negedge clk);
                end
                check("timeout_latency", n, TIMEOUT_CYCLES);
                check("timeout_err_set", 32'(timeout_err), 1);
                check("timeout_adc_off", 32'(adc_enable), 0);
                w[2] = 8'h00;
            end else
`endif
            begin
                hold = (mode == 1 && r == 0) ? PART_HOLD : $urandom_range(0, 5);
                part = (mode == 1 && r == 0) ? 3'b101 : COLUMNS'($urandom_range(0, 6));
                col_done = part;
                early = 1'b0;
                for (int i = 0; i < hold; i++) begin
                    pix.ready = 1'($urandom);
                    early |= pix.valid | !adc_enable;
                    @(negedge clk);
                end
                early |= pix.valid;
                check($sformatf("partial_wait_r%0d", r), 32'(early), 0);
                col_done = ALL_DONE;
                @(negedge clk);
                check($sformatf("capture_lat_r%0d", r), 32'(pix.valid), 1);
                check($sformatf("adc_off_r%0d", r), 32'(adc_enable), 0);
            end
            col_done = '0;
            col_data = {$urandom, $urandom};
            for (int c = 0; c < COLUMNS; c++) begin
                e.data = w[c];
                e.row  = r;
                e.col  = c;
                e.last = (r == ROWS - 1) && (c == COLUMNS - 1);
                exp_q.push_back(e);
            end

            xfers = 0;
            k = 0;
            while (xfers < COLUMNS && k < 200) begin
                if (mode == 1 && r == 0) pix.ready = 1'b1;
                else if (mode == 1 && r == 1) pix.ready = !(k >= 1 && k <= 5);
                else pix.ready = ($urandom_range(0, 2) != 0);
                check($sformatf("valid_drain_r%0d", r), 32'(pix.valid), 1);
                if (exp_q.size() > 0) begin
                    check($sformatf("data_r%0d", r), 32'(pix.data), 32'(exp_q[0].data));
                    check($sformatf("row_r%0d", r), 32'(pix.row), exp_q[0].row);
                    check($sformatf("col_r%0d", r), 32'(pix.col), exp_q[0].col);
                    check($sformatf("last_r%0d", r), 32'(pix.last), 32'(exp_q[0].last));
                    if (pix.valid && pix.ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
                if (abort_row == r && xfers == 1) begin
                    reset = 1'b0;
                    @(negedge clk);
                    check_all_zero("mid_reset");
                    reset = 1'b1;
                    pix.ready = 1'b0;
                    exp_q.delete();
                    @(negedge clk);
                    check("post_reset_idle", 32'({busy, erase}), 0);
                    return;
                end
                k++;
                @(negedge clk);
            end
            check($sformatf("xfers_r%0d", r), xfers, COLUMNS);
            if (mode == 1 && r == 0) check("row0_consecutive", k, COLUMNS);
        end

        pix.ready = 1'($urandom);
        check("frame_done_pulse", 32'(frame_done), 1);
        check("busy_in_done", 32'(busy), 1);
        check("valid_in_done", 32'({pix.valid, pix.last}), 0);
        te = 1'b0;
`ifdef PIXEL_READOUT_TIMEOUT_EN
        te = (mode == 2);
`endif
        check("timeout_err_end", 32'(timeout_err), 32'(te));
        start = 1'b1;
        @(negedge clk);
        check("frame_done_once", 32'(frame_done), 0);
        check("busy_fall", 32'(busy), 0);
        if (!chain) begin
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_ignored", 32'({busy, erase}), 0);
        end
    endtask

    initial begin
        pix.ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        run_frame(1, -1, 1'b0);
        run_frame(0, -1, 1'b1);
        run_frame(0, 1, 1'b0);
        run_frame(0, -1, 1'b0);
`ifdef PIXEL_READOUT_TIMEOUT_EN
        run_frame(2, -1, 1'b0);
        run_frame(0, -1, 1'b0);
`endif
        for (int f = 0; f < 4; f++) run_frame(0, -1, (f == 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_array_readout_seq.md
Name: pixel_array_readout_seq

Overview:
- Parametrised frame sequencer for the pixel array. Generalised in row count, column count and ADC resolution.
- Per frame: drives global ERASE and EXPOSE phases, then scans rows one at a time.
- Per row: enables the column SAR ADCs, waits for every column's done, captures all column codes into a row buffer, then streams them out one word at a time on a valid/ready interface.
- Replaces the free-running "all done" detect with a controlled, back-pressurable readout path.

Parameters:
- ROWS, 3, number of pixel rows scanned per frame (>=1)
- COLUMNS, 3, number of column ADCs (>=1)
- RESOLUTION, 8, ADC code width in bits
- ERASE_CYCLES, 4, clock cycles ERASE is held high (>=1)
- EXPOSE_CYCLES, 16, clock cycles EXPOSE is held high (>=1)
- ROW_W, $clog2(ROWS) (min 1), width of row index
- COL_W, $clog2(COLUMNS) (min 1), width of column index
- TIMEOUT_CYCLES, 255, max CONVERT cycles per row (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE
- erase  out  1  pixel erase strobe to array
- expose  out  1  pixel expose strobe to array
- adc_enable  out  1  enables column ADCs for the current row
- row_select  out  ROW_W  row decoder select
- col_done  in  COLUMNS  per-column ADC conversion complete (level)
- col_data  in  COLUMNS*RESOLUTION  packed ADC codes; column k at bits [k*RESOLUTION +: RESOLUTION]
- pix_valid  out  1  output word valid
- pix_ready  in  1  downstream accepts word
- pix_data  out  RESOLUTION  pixel code
- pix_row  out  ROW_W  row index of pix_data
- pix_col  out  COL_W  column index of pix_data
- pix_last  out  1  high with the final word of the frame
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last word is accepted
- timeout_err  out  1  sticky row-timeout flag (tied 0 without the option)

Behaviour:
- Reset (reset==0 at a clk edge) returns to IDLE from any state, including mid-frame.
  - All outputs 0; row_select = 0; row and column counters cleared; row buffer contents don't-care.
- States: IDLE, ERASE, EXPOSE, CONVERT, DRAIN, DONE.
- IDLE: start==1 -> ERASE. start is ignored in every other state.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles -> EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles -> CONVERT with row=0.
- CONVERT:
  - adc_enable=1; row_select=row.
  - When &col_done==1 in cycle N: capture col_data into the row buffer at edge N+1, set adc_enable=0, col=0, and enter DRAIN.
  - pix_valid=1 from cycle N+1.
  - Partial done (some columns high) keeps waiting.
- DRAIN:
  - adc_enable=0, so there is >=1 low cycle between rows and the ADCs re-arm.
  - pix_data = buffer[col]; pix_row = row; pix_col = col.
  - Word transfers on pix_valid & pix_ready. pix_data, pix_row and pix_col stay stable while pix_valid & !pix_ready.
  - On transfer with col<COLUMNS-1: col++.
  - On transfer with col==COLUMNS-1 and row<ROWS-1: row++, pix_valid=0 next cycle -> CONVERT.
  - On transfer with col==COLUMNS-1 and row==ROWS-1: -> DONE.
- pix_last=1 only when row==ROWS-1, col==COLUMNS-1 and pix_valid=1.
- DONE: frame_done=1 for one cycle -> IDLE. A start in that same cycle is ignored.
- Back-to-back frames: a start on the first IDLE cycle is accepted.
- pix_ready while pix_valid=0 has no effect.
- col_done and col_data are ignored outside CONVERT.

Optional Feature:
- Macro: PIXEL_READOUT_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in CONVERT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without &col_done, the controller captures col_data anyway, with columns whose done is 0 forced to code 0.
  - It then sets timeout_err=1 and enters DRAIN normally.
  - timeout_err stays set until reset or the next accepted start.
- Undefined: no counter; CONVERT waits indefinitely; timeout_err constant 0.

Test Plan:
- Defaults, ERASE_CYCLES=2, EXPOSE_CYCLES=4; start pulse -> erase high exactly 2 cycles, then expose high exactly 4 cycles, then adc_enable=1 with row_select=0; busy=1 throughout.
- Row 0: col_done=3'b111 with col_data {8'h30,8'h20,8'h10}, pix_ready=1 -> pix words 8'h10, 8'h20, 8'h30 with pix_col 0, 1, 2 and pix_row=0 on 3 consecutive cycles, then adc_enable re-asserts with row_select=1.
- Back-pressure: pix_ready=0 for 5 cycles mid-row -> pix_valid stays 1; pix_data and pix_col stay constant; no word is lost or duplicated.
- Partial done: col_done=3'b101 held 10 cycles, then 3'b111 -> no capture until all three are high; capture latency is 1 cycle.
- Full frame of 3 rows -> 9 words; pix_last only on (row 2, col 2); frame_done pulses 1 cycle later; busy falls; a start during DONE is ignored.
- reset=0 for one edge during DRAIN of row 1 -> all outputs 0, state IDLE; a new start produces a complete 9-word frame.
- With PIXEL_READOUT_TIMEOUT_EN and TIMEOUT_CYCLES=8: col_done=3'b011 held -> after 8 CONVERT cycles, column 2 reads 0 and timeout_err=1.
